// File: rtl/vend_ctrl_if.sv
// rtl/vend_ctrl_if.sv - coin/cancel inputs and dispense/change outputs of the vending controller
interface vend_ctrl_if #(
   parameter int CREDIT_W = 4
);
   logic                coin1_n;
   logic                coin2_n;
   logic                cancel_n;
   logic                vend_led;
   logic [CREDIT_W-1:0] change;
   logic                change_vld;
   logic [CREDIT_W-1:0] credit;
   logic                busy;

   modport master (
      output coin1_n, coin2_n, cancel_n,
      input  vend_led, change, change_vld, credit, busy
   );

   modport slave (
      input  coin1_n, coin2_n, cancel_n,
      output vend_led, change, change_vld, credit, busy
   );
endinterface

// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - coin-operated vending controller with debounced inputs and change/refund strobe
module vend_ctrl #(
   parameter int PRICE      = 3,
   parameter int DEB_CYCLES = 2,
   parameter int LED_CYCLES = 50,
   parameter int CREDIT_W   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   vend_ctrl_if.slave  bus
);
   localparam int DCW = $clog2(DEB_CYCLES + 1);
   localparam int LCW = $clog2(LED_CYCLES + 1);
   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
   localparam logic [DCW-1:0]      DEB_LAST = DCW'(DEB_CYCLES - 1);
   localparam logic [LCW-1:0]      LED_LAST = LCW'(LED_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;

   // channel order: bit 0 = coin1, bit 1 = coin2, bit 2 = cancel
   logic [2:0]     raw;
   logic [2:0]     sync1;
   logic [2:0]     sync2;
   logic [DCW-1:0] deb_cnt [3];
   logic [2:0]     armed;
   logic [2:0]     ev;

   state_t              state;
   logic [CREDIT_W-1:0] credit_q;
   logic [CREDIT_W-1:0] change_q;
   logic                change_vld_q;
   logic                vend_led_q;
   logic                busy_q;
   logic [LCW-1:0]      led_cnt;

   logic [CREDIT_W-1:0] add;
   logic [CREDIT_W-1:0] credit_next;

   assign raw = {bus.cancel_n, bus.coin2_n, bus.coin1_n};

   // two-flop synchronisers; idle level of the sensors is high
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= 3'b111;
         sync2 <= 3'b111;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // an event fires on the DEB_CYCLES-th consecutive low cycle of an armed channel
   for (genvar i = 0; i < 3; i++) begin : g_ev
      assign ev[i] = armed[i] && !sync2[i] && (deb_cnt[i] == DEB_LAST);
   end

   // debounce: armed channels count low cycles, disarmed channels count high cycles to re-arm
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            deb_cnt[i] <= '0;
            armed[i]   <= 1'b1;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (armed[i]) begin
               if (sync2[i]) begin
                  deb_cnt[i] <= '0;
               end else if (ev[i]) begin
                  deb_cnt[i] <= '0;
                  armed[i]   <= 1'b0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + DCW'(1);
               end
            end else begin
               if (!sync2[i]) begin
                  deb_cnt[i] <= '0;
               end else if (deb_cnt[i] == DEB_LAST) begin
                  deb_cnt[i] <= '0;
                  armed[i]   <= 1'b1;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + DCW'(1);
               end
            end
         end
      end
   end

   // both coins in one cycle add 3; width headroom guarantees no wrap below PRICE+3
   assign add         = (ev[0] ? CREDIT_W'(1) : '0) + (ev[1] ? CREDIT_W'(2) : '0);
   assign credit_next = credit_q + add;

   // main FSM with registered outputs; change is zero whenever its strobe is low
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         credit_q     <= '0;
         change_q     <= '0;
         change_vld_q <= 1'b0;
         vend_led_q   <= 1'b0;
         busy_q       <= 1'b0;
         led_cnt      <= '0;
      end else begin
         change_q     <= '0;
         change_vld_q <= 1'b0;
         case (state)
            IDLE, COLLECT: begin
               if (add != '0) begin
                  if (credit_next >= PRICE_C) begin
                     // a vend wins over a simultaneous cancel
                     state        <= VEND;
                     vend_led_q   <= 1'b1;
                     busy_q       <= 1'b1;
                     change_vld_q <= 1'b1;
                     change_q     <= credit_next - PRICE_C;
                     credit_q     <= '0;
                     led_cnt      <= '0;
                  end else if (ev[2]) begin
                     state        <= REFUND;
                     change_vld_q <= 1'b1;
                     change_q     <= credit_next;
                     credit_q     <= '0;
                  end else begin
                     state    <= COLLECT;
                     credit_q <= credit_next;
                  end
               end else if (ev[2] && state == COLLECT) begin
                  state        <= REFUND;
                  change_vld_q <= 1'b1;
                  change_q     <= credit_q;
                  credit_q     <= '0;
               end
            end
            VEND: begin
               // events arriving while dispensing are dropped
               if (led_cnt == LED_LAST) begin
                  state      <= IDLE;
                  vend_led_q <= 1'b0;
                  busy_q     <= 1'b0;
                  led_cnt    <= '0;
               end else begin
                  led_cnt <= led_cnt + LCW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.vend_led   = vend_led_q;
   assign bus.change     = change_q;
   assign bus.change_vld = change_vld_q;
   assign bus.credit     = credit_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - scoreboard bench for vend_ctrl with directed coin/cancel vectors
module tb_vend_ctrl;
   localparam int CW = 4;

   typedef struct {
      logic          is_vend;
      logic [CW-1:0] change;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   exp_t sb_q[$];

   vend_ctrl_if #(.CREDIT_W(CW)) bus ();

   vend_ctrl #(
      .PRICE(3), .DEB_CYCLES(2), .LED_CYCLES(50), .CREDIT_W(CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_strobe(input logic is_vend, input int change);
      exp_t e;
      e.is_vend = is_vend;
      e.change  = CW'(change);
      sb_q.push_back(e);
   endtask

   // drive selected sensors low for low_cyc cycles, then leave them high for gap_cyc cycles
   task automatic pulse(input logic c1, input logic c2, input logic cn,
                        input int low_cyc, input int gap_cyc);
      @(posedge clk); #2;
      if (c1) bus.coin1_n  = 1'b0;
      if (c2) bus.coin2_n  = 1'b0;
      if (cn) bus.cancel_n = 1'b0;
      repeat (low_cyc) @(posedge clk);
      #2;
      bus.coin1_n  = 1'b1;
      bus.coin2_n  = 1'b1;
      bus.cancel_n = 1'b1;
      repeat (gap_cyc) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("vend_end_busy", int'(bus.busy), 0);
   endtask

   // monitor: pops the scoreboard on every change strobe and times each vend_led pulse
   initial begin
      logic prev_led = 1'b0;
      logic aborted  = 1'b0;
      int   led_len  = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.change_vld) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_strobe", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("strobe_change", int'(bus.change), int'(e.change));
               chk("strobe_vend_led", int'(bus.vend_led), int'(e.is_vend));
            end
         end
         if (bus.vend_led && !prev_led) begin
            led_len = 1;
            aborted = 1'b0;
         end else if (bus.vend_led) begin
            led_len++;
         end
         if (!rst_n) aborted = 1'b1;
         if (!bus.vend_led && prev_led && !aborted)
            chk("vend_led_cycles", led_len, 50);
         prev_led = bus.vend_led;
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.coin1_n  = 1'b1;
      bus.coin2_n  = 1'b1;
      bus.cancel_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_credit", int'(bus.credit), 0);
      chk("rst_vend_led", int'(bus.vend_led), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_change", int'(bus.change), 0);
      chk("rst_change_vld", int'(bus.change_vld), 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // three single-unit coins reach the price exactly
      pulse(1, 0, 0, 5, 8);
      chk("c1_credit1", int'(bus.credit), 1);
      pulse(1, 0, 0, 5, 8);
      chk("c1_credit2", int'(bus.credit), 2);
      expect_strobe(1'b1, 0);
      pulse(1, 0, 0, 5, 8);
      chk("c1_vend_busy", int'(bus.busy), 1);
      chk("c1_vend_credit", int'(bus.credit), 0);
      wait_idle();

      // two double coins overshoot by one
      pulse(0, 1, 0, 5, 8);
      chk("c2_credit2", int'(bus.credit), 2);
      expect_strobe(1'b1, 1);
      pulse(0, 1, 0, 5, 8);
      wait_idle();
      chk("c2_after_credit", int'(bus.credit), 0);

      // refund from COLLECT, then cancel in IDLE must be silent
      pulse(1, 0, 0, 5, 8);
      chk("rf_credit1", int'(bus.credit), 1);
      expect_strobe(1'b0, 1);
      pulse(0, 0, 1, 5, 8);
      chk("rf_credit0", int'(bus.credit), 0);
      chk("rf_vend_led", int'(bus.vend_led), 0);
      pulse(0, 0, 1, 5, 8);
      chk("idle_cancel_credit", int'(bus.credit), 0);

      // simultaneous coins vend with no change; coins during VEND are lost
      expect_strobe(1'b1, 0);
      pulse(1, 1, 0, 5, 8);
      chk("both_busy", int'(bus.busy), 1);
      pulse(1, 0, 0, 5, 8);
      pulse(0, 1, 0, 5, 8);
      wait_idle();
      repeat (5) @(negedge clk);
      chk("vend_coins_dropped", int'(bus.credit), 0);

      // glitch rejected, long hold counts once
      pulse(1, 0, 0, 1, 8);
      chk("glitch_credit", int'(bus.credit), 0);
      pulse(1, 0, 0, 50, 8);
      chk("hold_credit", int'(bus.credit), 1);
      expect_strobe(1'b0, 1);
      pulse(0, 0, 1, 5, 8);
      chk("hold_refund_credit", int'(bus.credit), 0);

      // reset during VEND aborts without a strobe
      pulse(0, 1, 0, 5, 8);
      expect_strobe(1'b1, 0);
      pulse(1, 0, 0, 5, 8);
      chk("pre_rst_busy", int'(bus.busy), 1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_vend_led", int'(bus.vend_led), 0);
      chk("mid_rst_busy", int'(bus.busy), 0);
      chk("mid_rst_credit", int'(bus.credit), 0);
      repeat (60) @(negedge clk);
      chk("post_rst_credit", int'(bus.credit), 0);
      chk("scoreboard_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter PRICE, default 3, item price in coin units (1..12).
REQ-002 Parameter DEB_CYCLES, default 2, cycles a synchronised coin input must stay low to count as a coin.
REQ-003 Parameter LED_CYCLES, default 50, number of cycles vend_led stays high per vend.
REQ-004 Parameter CREDIT_W, default 4, width of credit/change; SHALL satisfy 2^CREDIT_W > PRICE+2.
REQ-005 clk  input  1  system clock, rising-edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 coin1_n  input  1  1-unit coin sensor, active-low, asynchronous to clk.
REQ-008 coin2_n  input  1  2-unit coin sensor, active-low, asynchronous to clk.
REQ-009 cancel_n  input  1  refund request, active-low, asynchronous, same conditioning as coins.
REQ-010 vend_led  output  1  high while dispensing.
REQ-011 change  output  CREDIT_W  change/refund amount, valid only while change_vld is high.
REQ-012 change_vld  output  1  one-cycle strobe qualifying change.
REQ-013 credit  output  CREDIT_W  current accumulated credit.
REQ-014 busy  output  1  high in VEND state.

Function
REQ-015 Each of coin1_n, coin2_n and cancel_n SHALL pass through a 2-flop synchroniser, then a per-channel debounce counter.
REQ-016 A channel SHALL emit exactly one 1-cycle event when its synchronised level has been low for DEB_CYCLES consecutive cycles; it re-arms only after the level has been high for DEB_CYCLES consecutive cycles.
REQ-017 Low pulses shorter than DEB_CYCLES SHALL produce no event.
REQ-018 FSM states: IDLE (credit=0), COLLECT (0<credit<PRICE), VEND, REFUND (one cycle).
REQ-019 In IDLE/COLLECT, a coin event SHALL add 1 (coin1) or 2 (coin2) to credit on the next edge; both in the same cycle add 3.
REQ-020 If the summed credit (credit_next) is >= PRICE, then on that same edge: state->VEND, vend_led=1, busy=1, change_vld=1, change=credit_next-PRICE, credit=0.
REQ-021 Otherwise credit=credit_next and state->COLLECT.
REQ-022 VEND SHALL last exactly LED_CYCLES cycles, then vend_led=0, busy=0, state->IDLE.
REQ-023 Coin and cancel events during VEND SHALL be discarded without credit or refund.
REQ-024 Cancel event in COLLECT (no coin event in the same cycle) SHALL give on the next edge: state->REFUND, change=credit, change_vld=1, credit=0; the following edge SHALL give state->IDLE.
REQ-025 Cancel event in IDLE SHALL be ignored; change_vld stays 0.
REQ-026 Cancel and coin events in the same cycle: the coin is added first; if credit_next >= PRICE, vend per REQ-020 and the cancel is dropped; otherwise refund credit_next per REQ-024.
REQ-027 Credit SHALL never exceed PRICE-1 at rest; no wrap-around can occur given REQ-004.
REQ-028 change SHALL hold 0 whenever change_vld is 0.

Reset
REQ-029 When rst_n is sampled low at a rising edge: state=IDLE, credit=0, change=0, change_vld=0, vend_led=0, busy=0, all synchroniser flops=1 (inactive), all debounce counters=0.
REQ-030 Reset asserted mid-VEND or mid-COLLECT SHALL abort the operation and discard credit with no refund strobe; a coin held low across reset release SHALL count only after satisfying REQ-016.

Verification
Defaults used; clk period 20 ns.
REQ-031 coin1 pulse 3 times (low 100 ns each, high 100 ns between) -> credit 1, 2, then vend_led high 50 cycles, change_vld pulse with change=0, credit=0.
REQ-032 coin2, then coin2 -> credit 2, then vend with change=1 on the same edge vend_led rises.
REQ-033 coin1, then cancel -> change_vld one cycle with change=1, credit 0, vend_led stays 0; cancel in IDLE -> no strobe.
REQ-034 coin1_n and coin2_n driven low simultaneously from IDLE -> single vend, change=0; coins inserted during VEND -> credit stays 0 after VEND.
REQ-035 20 ns low glitch on coin1_n -> no credit change; coin held low 1 us -> exactly one credit increment.
REQ-036 rst_n low for 1 cycle during VEND -> vend_led and busy drop on that edge, credit 0, no change_vld.
